// File: rtl/mcu_bus_sync_pkg.sv
// Shared definitions for the MCU bus bridge: FSM state encoding,
// byte-lane indices and the post-reset synchroniser flush count.
package mcu_bus_sync_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_HOLD    = 2'd3
   } state_t;

   localparam int BE_LO = 0;
   localparam int BE_HI = 1;

   // Wide enough to count the deepest legal synchroniser (3 stages)
   localparam int FLUSH_W = 2;

   // Number of cycles the synchroniser needs after reset before its
   // outputs reflect the pins rather than the reset value.
   function automatic logic [FLUSH_W-1:0] flush_count(input int stages);
      int v;
      v = stages;
      return v[FLUSH_W-1:0];
   endfunction

endpackage

// File: rtl/cc_sync_bit.sv
// Single-bit clock-domain-crossing flop chain with a selectable
// value loaded on synchronous active-low reset.
module cc_sync_bit
   import mcu_bus_sync_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic _reset,
   input  logic i_rst_val,
   input  logic i_d,
   output logic o_q
);

   logic [SYNC_STAGES-1:0] r_chain;

   // Shift the asynchronous input through the flop chain
   always_ff @(posedge clk) begin
      if (!_reset) begin
         r_chain <= {SYNC_STAGES{i_rst_val}};
      end else begin
         r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
      end
   end

   assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/mcu_bus_sync.sv
// Bridge from the asynchronous MCU bus (active-low strobes) to the
// synchronous register file: one clocked access per MCU strobe, read
// data captured and held for the MCU until the strobe is released.
module mcu_bus_sync
   import mcu_bus_sync_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  _reset,
   input  logic                  _mcu_mreq,
   input  logic                  _mcu_rd,
   input  logic                  _mcu_wr,
   input  logic [1:0]            mcu_be,
   input  logic [ADDR_WIDTH-1:0] mcu_addr,
   input  logic [DATA_WIDTH-1:0] mcu_wdata,
   output logic [DATA_WIDTH-1:0] mcu_rdata,
   output logic                  mcu_rdata_oe,
   output logic                  mcu_ready,
   output logic                  reg_en,
   output logic                  reg_rd,
   output logic                  reg_wr,
   output logic [1:0]            reg_be,
   output logic [ADDR_WIDTH-1:0] reg_addr,
   output logic [DATA_WIDTH-1:0] reg_wdata,
   input  logic [DATA_WIDTH-1:0] reg_rdata
);

   localparam logic [FLUSH_W-1:0] FLUSH_INIT = flush_count(SYNC_STAGES);
   localparam logic [FLUSH_W-1:0] FLUSH_ONE  = {{(FLUSH_W-1){1'b0}}, 1'b1};
   localparam logic [FLUSH_W-1:0] FLUSH_ZERO = '0;

   // Requests are carried active-low through the synchronisers so that
   // the reset value of every flop (1) means "no request".
   logic w_nreq_rd;
   logic w_nreq_wr;
   logic w_nrd_sync;
   logic w_nwr_sync;
   logic w_s_rd;
   logic w_s_wr;
   logic w_s_dir;

   state_t r_state;
   state_t w_state_nxt;

   logic                  r_dir;
   logic                  r_armed;
   logic [FLUSH_W-1:0]    r_flush;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [1:0]            r_be;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic w_accept;
   logic w_illegal;
   logic w_en;
   logic w_rd;
   logic w_wr;
   logic w_ready;
   logic w_oe;

   assign w_nreq_rd = _mcu_mreq | _mcu_rd;
   assign w_nreq_wr = _mcu_mreq | _mcu_wr;

   cc_sync_bit #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_rd (
      .clk       (clk),
      ._reset    (_reset),
      .i_rst_val (1'b1),
      .i_d       (w_nreq_rd),
      .o_q       (w_nrd_sync)
   );

   cc_sync_bit #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_wr (
      .clk       (clk),
      ._reset    (_reset),
      .i_rst_val (1'b1),
      .i_d       (w_nreq_wr),
      .o_q       (w_nwr_sync)
   );

   assign w_s_rd  = ~w_nrd_sync;
   assign w_s_wr  = ~w_nwr_sync;
   assign w_s_dir = r_dir ? w_s_rd : w_s_wr;

   // Next-state and access outputs. An access is only accepted when
   // the bridge is armed, i.e. both strobes have been seen released
   // since the last access, reset or illegal request. This keeps a
   // strobe that is still low after reset or after an aborted access
   // from issuing a (re)access.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_illegal   = 1'b0;
      w_en        = 1'b0;
      w_rd        = 1'b0;
      w_wr        = 1'b0;
      w_ready     = 1'b0;
      w_oe        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_s_rd && w_s_wr) begin
               w_illegal = 1'b1;
            end else if (r_armed && (w_s_rd ^ w_s_wr)) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            w_en        = 1'b1;
            w_rd        = r_dir;
            w_wr        = ~r_dir;
            w_state_nxt = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            w_en        = 1'b1;
            w_state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            w_ready = w_s_dir;
            w_oe    = r_dir & w_s_rd;
            if (!w_s_dir) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Latch address, byte enables, write data and direction on acceptance
   always_ff @(posedge clk) begin
      if (!_reset) begin
         r_addr  <= '0;
         r_be    <= '0;
         r_wdata <= '0;
         r_dir   <= 1'b0;
      end else if (w_accept) begin
         r_addr       <= mcu_addr;
         r_be[BE_LO]  <= mcu_be[BE_LO];
         r_be[BE_HI]  <= mcu_be[BE_HI];
         r_wdata      <= mcu_wdata;
         r_dir        <= w_s_rd;
      end
   end

   // Post-reset flush of the synchronisers, then arm on both strobes idle
   always_ff @(posedge clk) begin
      if (!_reset) begin
         r_flush <= FLUSH_INIT;
         r_armed <= 1'b0;
      end else begin
         if (r_flush != FLUSH_ZERO) begin
            r_flush <= r_flush - FLUSH_ONE;
         end
         if (w_accept || w_illegal) begin
            r_armed <= 1'b0;
         end else if ((r_flush == FLUSH_ZERO) && !w_s_rd && !w_s_wr) begin
            r_armed <= 1'b1;
         end
      end
   end

   // Capture register read data; deliberately not cleared by reset
   always_ff @(posedge clk) begin
      if (_reset && (r_state == ST_CAPTURE) && r_dir) begin
         r_rdata <= reg_rdata;
      end
   end

   assign reg_en       = w_en;
   assign reg_rd       = w_rd;
   assign reg_wr       = w_wr;
   assign reg_be       = r_be;
   assign reg_addr     = r_addr;
   assign reg_wdata    = r_wdata;
   assign mcu_ready    = w_ready;
   assign mcu_rdata_oe = w_oe;
   assign mcu_rdata    = r_rdata;

endmodule

// File: doc/mcu_bus_sync.md
Name: mcu_bus_sync

Overview:
- Bridges the asynchronous external MCU bus (active-low strobes) into the system clock domain.
- Synchronises the strobes, latches address, byte enables and write data, and issues exactly one clocked access per MCU cycle to the downstream register file (en/rd/wr/be/addr/data).
- Captures register read data and holds it for the MCU until the strobe is released.
- Sits directly upstream of the register file.

Parameters:
ADDR_WIDTH, 8, word address width (MCU byte address >> 1)
DATA_WIDTH, 16, data bus width; must be 16 (two byte lanes)
SYNC_STAGES, 2, synchroniser flops per strobe; legal values 2..3

Ports:
clk  in  1  system clock
_reset  in  1  synchronous, active-low reset
_mcu_mreq  in  1  MCU memory request, active-low, asynchronous
_mcu_rd  in  1  MCU read strobe, active-low, asynchronous
_mcu_wr  in  1  MCU write strobe, active-low, asynchronous
mcu_be  in  2  byte enables {hi, lo}, active-high, stable while strobe low
mcu_addr  in  ADDR_WIDTH  word address, stable while strobe low
mcu_wdata  in  DATA_WIDTH  write data, stable while _mcu_wr low
mcu_rdata  out  DATA_WIDTH  latched read data
mcu_rdata_oe  out  1  MCU data pad output enable
mcu_ready  out  1  access complete; MCU may release strobe
reg_en  out  1  register access enable
reg_rd  out  1  register read pulse
reg_wr  out  1  register write pulse
reg_be  out  2  latched byte enables
reg_addr  out  ADDR_WIDTH  latched address
reg_wdata  out  DATA_WIDTH  latched write data
reg_rdata  in  DATA_WIDTH  register read data, valid the cycle after reg_rd

Behaviour:
- Reset: synchronous, sampled on the clk rising edge while _reset=0.
  - FSM goes to IDLE; synchroniser flops load 1 (inactive).
  - All outputs go to 0, except mcu_rdata, which holds its previous value.
- Synchronisation:
  - Define req_rd = ~_mcu_mreq & ~_mcu_rd and req_wr = ~_mcu_mreq & ~_mcu_wr.
  - Each is passed through SYNC_STAGES flops; s_rd and s_wr are the final-stage outputs.
- FSM states: IDLE, ACCESS, CAPTURE, HOLD.
  - IDLE → ACCESS when exactly one of s_rd, s_wr is 1.
    - On this transition, latch mcu_addr→reg_addr, mcu_be→reg_be and mcu_wdata→reg_wdata.
    - Also record the direction bit dir (1 = read).
  - If s_rd and s_wr are both 1, the request is illegal: remain in IDLE and issue no access.
  - ACCESS lasts one cycle and always → CAPTURE.
    - reg_en=1; reg_rd=dir; reg_wr=~dir.
  - CAPTURE lasts one cycle and always → HOLD.
    - reg_en=1; reg_rd=0; reg_wr=0.
    - If dir=1, reg_rdata is loaded into mcu_rdata at the end of this cycle.
  - HOLD: reg_en=0; mcu_ready=1; mcu_rdata_oe = dir & s_rd.
    - HOLD → IDLE when the recorded direction's synced strobe (s_rd if dir=1, else s_wr) is 0.
    - mcu_ready drops in that same cycle.
- Latency: strobe falling at the pin → reg_en high after SYNC_STAGES+1 clk edges (worst case). mcu_ready follows reg_en by 2 cycles.
- Exactly one reg_rd or reg_wr pulse per MCU strobe assertion. Holding the strobe low indefinitely never re-issues the access.
- Strobe released before HOLD: the access still completes; HOLD exits on its first cycle.
- Back-to-back: a new strobe is accepted only after returning to IDLE, so at least 1 idle cycle separates accesses.
- reg_addr, reg_be and reg_wdata are stable from ACCESS through HOLD. They change only on the IDLE→ACCESS transition.
- Reset during ACCESS or CAPTURE aborts the access. The aborted access is not retried.

Decomposition:
- Shared package: state encoding (2-bit IDLE=0, ACCESS=1, CAPTURE=2, HOLD=3) and the byte-enable index constants BE_LO=0, BE_HI=1.
- One sub-module: cc_sync_bit, a parameterised SYNC_STAGES flop chain with a reset value input. It is instantiated once each for req_rd and req_wr.

Test Plan:
- Reset: hold _reset=0 for 3 cycles with the strobes low → reg_en, reg_rd, reg_wr, mcu_ready and mcu_rdata_oe are all 0; state is IDLE; no pulse after release until strobes cycle high→low.
- Word write: addr=0x04, wdata=0xCAFE, be=2'b11, _mreq=_wr=0 held 10 cycles → a single reg_wr pulse with reg_addr=0x04, reg_wdata=0xCAFE, reg_be=2'b11; mcu_ready=1 two cycles after reg_en; mcu_ready returns to 0 ≤SYNC_STAGES+1 cycles after the strobe rises.
- Byte write: addr=0x0D, be=2'b10, wdata=0xFFFF → reg_be=2'b10 during ACCESS; exactly one reg_wr.
- Read: the model returns 0xBEEF the cycle after reg_rd at addr=0x08 → mcu_rdata=0xBEEF from HOLD onward; mcu_rdata_oe=1 only while s_rd is 1; mcu_rdata is retained after the strobe is released.
- Illegal request: _rd=_wr=0 simultaneously → no reg_en asserted; FSM stays IDLE.
- Short strobe and mid-access reset: a 1-cycle _wr pulse still yields one complete write; asserting _reset=0 during CAPTURE → next cycle IDLE with outputs 0, and the next strobe is handled normally.
